// File: rtl/wb_regfile_commit.sv
// Write-back stage: selects WB data, commits it to the architectural register file,
// serves bypassed ID read ports and emits a registered commit trace plus retire counter.
module wb_regfile_commit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb_reg_write,
  input  logic              wb_mem_to_reg,
  input  logic [ADDR_W-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [DATA_W-1:0] wb_read_data,
  input  logic [31:0]       wb_instr,
  input  logic [31:0]       wb_pc,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              commit_valid,
  output logic [31:0]       commit_pc,
  output logic [31:0]       commit_instr,
  output logic              commit_we,
  output logic [ADDR_W-1:0] commit_reg,
  output logic [DATA_W-1:0] commit_data,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_en;
  logic              retire;

  // Zero-latency, write-first read: an in-flight WB write to the same index wins.
  function automatic logic [DATA_W-1:0] bypass_read(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] arr_val,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] r;
    if (addr == '0)
      r = '0;
    else if (we && (addr == waddr))
      r = wdata;
    else
      r = arr_val;
    return r;
  endfunction

  assign wb_data = wb_mem_to_reg ? wb_read_data : wb_alu_result;
  assign wr_en   = wb_reg_write && (wb_write_reg != '0);
  assign retire  = (wb_instr != 32'd0);

  always_comb begin
    rs_data  = bypass_read(rs_addr, regs[rs_addr], wb_reg_write, wb_write_reg, wb_data);
    rt_data  = bypass_read(rt_addr, regs[rt_addr], wb_reg_write, wb_write_reg, wb_data);
    dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
  end

  // Register file commit; bubbles with a write enable still update the array.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wb_write_reg] <= wb_data;
    end
  end

  // Commit trace: one-cycle valid pulse, payload holds between retires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_instr <= '0;
      commit_we    <= 1'b0;
      commit_reg   <= '0;
      commit_data  <= '0;
      retired_cnt  <= '0;
    end else begin
      commit_valid <= retire;
      if (retire) begin
        commit_pc    <= wb_pc;
        commit_instr <= wb_instr;
        commit_we    <= wr_en;
        commit_reg   <= wr_en ? wb_write_reg : '0;
        commit_data  <= wr_en ? wb_data : '0;
        retired_cnt  <= retired_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile_commit.sv
// Directed bench for wb_regfile_commit; a second instance with a 4-bit counter checks wrap.
module tb_wb_regfile_commit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_reg_write, wb_mem_to_reg;
  logic [4:0]  wb_write_reg, rs_addr, rt_addr, dbg_addr;
  logic [31:0] wb_alu_result, wb_read_data, wb_instr, wb_pc;
  logic [31:0] rs_data, rt_data, wb_data, dbg_data;
  logic        commit_valid, commit_we;
  logic [31:0] commit_pc, commit_instr, commit_data;
  logic [4:0]  commit_reg;
  logic [31:0] retired_cnt;

  logic [31:0] s_rs, s_rt, s_wb, s_dbg, s_pc, s_instr, s_data;
  logic        s_valid, s_we;
  logic [4:0]  s_reg;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_regfile_commit #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_write_reg(wb_write_reg), .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
    .wb_instr(wb_instr), .wb_pc(wb_pc), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wb_data(wb_data), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_instr(commit_instr), .commit_we(commit_we), .commit_reg(commit_reg),
    .commit_data(commit_data), .retired_cnt(retired_cnt)
  );

  wb_regfile_commit #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut_small (
    .clk(clk), .reset_n(reset_n), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_write_reg(wb_write_reg), .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
    .wb_instr(wb_instr), .wb_pc(wb_pc), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(s_rs), .rt_data(s_rt), .wb_data(s_wb), .dbg_addr(dbg_addr),
    .dbg_data(s_dbg), .commit_valid(s_valid), .commit_pc(s_pc),
    .commit_instr(s_instr), .commit_we(s_we), .commit_reg(s_reg),
    .commit_data(s_data), .retired_cnt(s_cnt)
  );

  task automatic set_idle();
    wb_reg_write  = 1'b0;
    wb_mem_to_reg = 1'b0;
    wb_write_reg  = 5'd0;
    wb_alu_result = 32'd0;
    wb_read_data  = 32'd0;
    wb_instr      = 32'd0;
    wb_pc         = 32'd0;
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] instr, input logic [31:0] pc);
    wb_reg_write  = we;
    wb_mem_to_reg = m2r;
    wb_write_reg  = rd;
    wb_alu_result = alu;
    wb_read_data  = rdata;
    wb_instr      = instr;
    wb_pc         = pc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    set_idle();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset_initial();
    #1;
    dbg_addr = 5'd5;
    #1;
    checks++; if (retired_cnt !== 32'd0) begin errors++; $display("FAIL init_cnt got %h exp 0", retired_cnt); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL init_valid got %b exp 0", commit_valid); end
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL init_dbg got %h exp 0", dbg_data); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_write();
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h55, 32'h1234_0001, 32'h100);
    #1;
    checks++; if (wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_wbdata got %h exp deadbeef", wb_data); end
    @(posedge clk); #1;
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL wr_valid got %b exp 1", commit_valid); end
    checks++; if (commit_reg !== 5'd5) begin errors++; $display("FAIL wr_reg got %0d exp 5", commit_reg); end
    checks++; if (commit_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_data got %h exp deadbeef", commit_data); end
    checks++; if (commit_we !== 1'b1) begin errors++; $display("FAIL wr_we got %b exp 1", commit_we); end
    checks++; if (commit_pc !== 32'h100) begin errors++; $display("FAIL wr_pc got %h exp 100", commit_pc); end
    checks++; if (commit_instr !== 32'h1234_0001) begin errors++; $display("FAIL wr_instr got %h exp 12340001", commit_instr); end
    checks++; if (dbg_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_dbg got %h exp deadbeef", dbg_data); end
    @(negedge clk);
    set_idle();
    @(posedge clk); #1;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL wr_pulse got %b exp 0", commit_valid); end
    checks++; if (commit_reg !== 5'd5) begin errors++; $display("FAIL wr_hold got %0d exp 5", commit_reg); end
    checks++; if (retired_cnt !== 32'd1) begin errors++; $display("FAIL wr_cnt got %0d exp 1", retired_cnt); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd8, 32'h88, 32'h0, 32'h2, 32'h104);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd7, 32'h9999, 32'h1234, 32'h3, 32'h108);
    rs_addr = 5'd7; rt_addr = 5'd7; dbg_addr = 5'd7;
    #1;
    checks++; if (rs_data !== 32'h1234) begin errors++; $display("FAIL byp_rs got %h exp 1234", rs_data); end
    checks++; if (rt_data !== 32'h1234) begin errors++; $display("FAIL byp_rt got %h exp 1234", rt_data); end
    checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL byp_dbg got %h exp 0", dbg_data); end
    rt_addr = 5'd8;
    #1;
    checks++; if (rt_data !== 32'h88) begin errors++; $display("FAIL byp_rt8 got %h exp 88", rt_data); end
    checks++; if (rs_data !== 32'h1234) begin errors++; $display("FAIL byp_rs_ind got %h exp 1234", rs_data); end
    @(negedge clk);
    set_idle();
    #1;
    checks++; if (dbg_data !== 32'h1234) begin errors++; $display("FAIL byp_commit got %h exp 1234", dbg_data); end
    checks++; if (rs_data !== 32'h1234) begin errors++; $display("FAIL byp_rs_arr got %h exp 1234", rs_data); end
  endtask

  task automatic test_r0();
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h4, 32'h10C);
    rs_addr = 5'd0; dbg_addr = 5'd0;
    #1;
    checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL r0_rs got %h exp 0", rs_data); end
    @(posedge clk); #1;
    checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL r0_rs_next got %h exp 0", rs_data); end
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL r0_dbg got %h exp 0", dbg_data); end
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL r0_valid got %b exp 1", commit_valid); end
    checks++; if (commit_we !== 1'b0) begin errors++; $display("FAIL r0_we got %b exp 0", commit_we); end
    checks++; if (commit_reg !== 5'd0) begin errors++; $display("FAIL r0_reg got %0d exp 0", commit_reg); end
    checks++; if (commit_data !== 32'd0) begin errors++; $display("FAIL r0_data got %h exp 0", commit_data); end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd10, 32'hA5A5, 32'h0, 32'h5, 32'h110);
    @(posedge clk); #2;
    reset_n = 1'b0;
    dbg_addr = 5'd5;
    #1;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", commit_valid); end
    checks++; if (retired_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", retired_cnt); end
    checks++; if (commit_reg !== 5'd0) begin errors++; $display("FAIL rst_reg got %0d exp 0", commit_reg); end
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL rst_r5 got %h exp 0", dbg_data); end
    dbg_addr = 5'd10;
    #1;
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL rst_r10 got %h exp 0", dbg_data); end
    drive(1'b1, 1'b0, 5'd11, 32'hBBBB, 32'h0, 32'h6, 32'h114);
    @(posedge clk); #1;
    dbg_addr = 5'd11;
    #1;
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL rst_lost got %h exp 0", dbg_data); end
    checks++; if (retired_cnt !== 32'd0) begin errors++; $display("FAIL rst_lost_cnt got %0d exp 0", retired_cnt); end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (dbg_data !== 32'hBBBB) begin errors++; $display("FAIL rst_first got %h exp bbbb", dbg_data); end
    checks++; if (retired_cnt !== 32'd1) begin errors++; $display("FAIL rst_first_cnt got %0d exp 1", retired_cnt); end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_bubbles();
    logic [31:0] instrs [6];
    int pulses;
    instrs[0] = 32'h11; instrs[1] = 32'h12; instrs[2] = 32'h13;
    instrs[3] = 32'h0;  instrs[4] = 32'h0;  instrs[5] = 32'h14;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 3) drive(1'b1, 1'b0, 5'd9, 32'h99, 32'h0, 32'h0, 32'h0);
      else        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, instrs[i], 32'(i * 4));
      @(posedge clk); #1;
      if (commit_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    set_idle();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (commit_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    dbg_addr = 5'd9;
    #1;
    checks++; if (retired_cnt !== 32'd4) begin errors++; $display("FAIL bub_cnt got %0d exp 4", retired_cnt); end
    checks++; if (pulses !== 4) begin errors++; $display("FAIL bub_pulses got %0d exp 4", pulses); end
    checks++; if (dbg_data !== 32'h99) begin errors++; $display("FAIL bub_write got %h exp 99", dbg_data); end
    checks++; if (commit_pc !== 32'd20) begin errors++; $display("FAIL bub_pc got %0d exp 20", commit_pc); end
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, 5'(i + 1), 32'(i * 3), 32'h0, 32'h100 + 32'(i), 32'(i * 4));
      @(posedge clk); #1;
      checks++;
      if (commit_pc !== 32'(i * 4) || commit_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_pc[%0d] got %h/%b exp %h/1", i, commit_pc, commit_valid, 32'(i * 4));
      end
      @(negedge clk);
    end
    set_idle();
    dbg_addr = 5'd17;
    #1;
    checks++; if (s_cnt !== 4'd1) begin errors++; $display("FAIL wrap_cnt got %0d exp 1", s_cnt); end
    checks++; if (retired_cnt !== 32'd17) begin errors++; $display("FAIL wide_cnt got %0d exp 17", retired_cnt); end
    checks++; if (dbg_data !== 32'd48) begin errors++; $display("FAIL b2b_r17 got %0d exp 48", dbg_data); end
    dbg_addr = 5'd3;
    #1;
    checks++; if (dbg_data !== 32'd6) begin errors++; $display("FAIL b2b_r3 got %0d exp 6", dbg_data); end
  endtask

  initial begin
    reset_n = 1'b0;
    set_idle();
    rs_addr = 5'd0; rt_addr = 5'd0; dbg_addr = 5'd0;
    test_reset_initial();
    test_write();
    test_bypass();
    test_r0();
    test_reset_mid();
    test_bubbles();
    test_back_to_back_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
